// File: rtl/point_on_curve_check.sv
// Checks that an affine point (x, y) satisfies y^2 = x^3 + a*x + b (mod p) using one shared
// bit-serial interleaved modular multiplier. Optional input range check: POC_RANGE_CHECK_EN.
module point_on_curve_check #(
  parameter int n = 231
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         inf,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  output logic         busy,
  output logic         done,
  output logic         on_curve,
  output logic         range_err
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_ADD1,
    S_ADD2,
    S_CMP,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic [n-1:0]   r_p;
  logic [n-1:0]   r_a;
  logic [n-1:0]   r_b;
  logic [n-1:0]   r_x;
  logic [n-1:0]   r_y;
  logic           r_inf;

  logic [n-1:0]   r_acc;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_op;
  logic [n-1:0]   r_s0;
  logic [n-1:0]   r_s1;
  logic [n-1:0]   r_s2;
  logic [n-1:0]   r_s3;
  logic [n-1:0]   r_sum;
  logic           r_match;
  logic           r_range_flag;

  logic           r_busy;
  logic           r_done;
  logic           r_on_curve;
  logic           r_range_err;

  logic [n-1:0]   w_mcand;
  logic [n-1:0]   w_mplier;
  logic           w_mul_bit;
  logic [n-1:0]   w_dbl;
  logic [n-1:0]   w_step;
  logic           w_mul_last;
  logic           w_range_bad;

  // Sum is formed one bit wider than the operands so p = 2^n-1 cannot wrap before reduction.
  function automatic logic [n-1:0] mod_add(input logic [n-1:0] op_a,
                                           input logic [n-1:0] op_b,
                                           input logic [n-1:0] mod_p);
    logic [n:0] sum;
    sum = {1'b0, op_a} + {1'b0, op_b};
    if (sum >= {1'b0, mod_p}) begin
      sum = sum - {1'b0, mod_p};
    end
    return sum[n-1:0];
  endfunction

`ifdef POC_RANGE_CHECK_EN
  assign w_range_bad = (r_x >= r_p) || (r_y >= r_p);
`else
  assign w_range_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_mul_last = (r_cnt == '0) && (r_op == 2'd3);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = S_MUL;
      S_MUL:   if (w_mul_last) w_next = S_ADD1;
      S_ADD1:  w_next = S_ADD2;
      S_ADD2:  w_next = S_CMP;
      S_CMP:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand schedule: s0=y*y, s1=x*x, s2=s1*x, s3=a*x; the multiplier is scanned MSB first.
  always_comb begin
    w_mcand  = '0;
    w_mplier = '0;
    case (r_op)
      2'd0: begin w_mcand = r_y;  w_mplier = r_y; end
      2'd1: begin w_mcand = r_x;  w_mplier = r_x; end
      2'd2: begin w_mcand = r_s1; w_mplier = r_x; end
      2'd3: begin w_mcand = r_a;  w_mplier = r_x; end
      default: begin w_mcand = '0; w_mplier = '0; end
    endcase
  end

  assign w_mul_bit = w_mplier[r_cnt];
  assign w_dbl     = mod_add(r_acc, r_acc, r_p);
  assign w_step    = w_mul_bit ? mod_add(w_dbl, w_mcand, r_p) : w_dbl;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      r_p          <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_inf        <= 1'b0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_op         <= '0;
      r_s0         <= '0;
      r_s1         <= '0;
      r_s2         <= '0;
      r_s3         <= '0;
      r_sum        <= '0;
      r_match      <= 1'b0;
      r_range_flag <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_on_curve   <= 1'b0;
      r_range_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_p         <= p;
            r_a         <= a;
            r_b         <= b;
            r_x         <= x;
            r_y         <= y;
            r_inf       <= inf;
            r_busy      <= 1'b1;
            r_on_curve  <= 1'b0;
            r_range_err <= 1'b0;
          end
        end
        S_LOAD: begin
          r_acc        <= '0;
          r_op         <= 2'd0;
          r_cnt        <= CW'(n - 1);
          r_range_flag <= w_range_bad;
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            case (r_op)
              2'd0:    r_s0 <= w_step;
              2'd1:    r_s1 <= w_step;
              2'd2:    r_s2 <= w_step;
              default: r_s3 <= w_step;
            endcase
            r_acc <= '0;
            r_cnt <= CW'(n - 1);
            r_op  <= r_op + 2'd1;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ADD1: r_sum   <= mod_add(r_s2, r_s3, r_p);
        S_ADD2: r_sum   <= mod_add(r_sum, r_b, r_p);
        S_CMP:  r_match <= (r_sum == r_s0);
        S_DONE: begin
          // Infinity always passes; an out-of-range coordinate always fails.
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_on_curve  <= r_inf | (r_match & ~r_range_flag);
          r_range_err <= ~r_inf & r_range_flag;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign on_curve  = r_on_curve;
  assign range_err = r_range_err;

endmodule

// File: tb/tb_point_on_curve_check.sv
// Scoreboard bench for point_on_curve_check at n=8; expectations come from an integer curve model.
module tb_point_on_curve_check;

  localparam int N   = 8;
  localparam int LAT = 4 * N + 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         inf;
  logic [N-1:0] p;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         busy;
  logic         done;
  logic         on_curve;
  logic         range_err;

  typedef struct {
    logic  oc;
    logic  re;
    bit    chk_oc;
    string name;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  point_on_curve_check #(.n(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .inf       (inf),
    .p         (p),
    .a         (a),
    .b         (b),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .on_curve  (on_curve),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  function automatic logic model_on_curve(input longint unsigned mp, input longint unsigned ma,
                                          input longint unsigned mb, input longint unsigned mx,
                                          input longint unsigned my);
    longint unsigned lhs;
    longint unsigned rhs;
    lhs = (my * my) % mp;
    rhs = (((mx * mx) % mp) * mx + ma * mx + mb) % mp;
    return (lhs == rhs);
  endfunction

  task automatic drive_start(input logic i_inf, input int unsigned ip, input int unsigned ia,
                             input int unsigned ib, input int unsigned ix, input int unsigned iy,
                             input string name);
    exp_t        e;
    bit          oor;
    logic [31:0] r0;
    logic [31:0] r1;
    oor      = (ix >= ip) || (iy >= ip);
    e.name   = name;
    e.chk_oc = 1'b1;
    e.re     = 1'b0;
    if (i_inf) begin
      e.oc = 1'b1;
    end else if (oor) begin
`ifdef POC_RANGE_CHECK_EN
      e.oc = 1'b0;
      e.re = 1'b1;
`else
      e.oc     = 1'b0;
      e.chk_oc = 1'b0;
`endif
    end else begin
      e.oc = model_on_curve(ip, ia, ib, ix, iy);
    end
    sb.push_back(e);
    @(negedge clk);
    inf   = i_inf;
    p     = N'(ip);
    a     = N'(ia);
    b     = N'(ib);
    x     = N'(ix);
    y     = N'(iy);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    r0 = $urandom;
    r1 = $urandom;
    x   = r0[7:0];
    y   = r0[15:8];
    a   = r0[23:16];
    b   = r0[31:24];
    p   = r1[7:0];
    inf = r1[8];
  endtask

  task automatic wait_result(input int pre);
    exp_t e;
    int   k;
    bit   seen;
    seen = 1'b0;
    e = sb.pop_front();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s busy_after_start: got %b want 1", e.name, busy);
    end
    for (k = pre + 1; k <= LAT + 20; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s done_timeout: got no done within %0d cycles want done at %0d", e.name,
               LAT + 20, LAT);
    end else begin
      if (k !== LAT) begin
        tests_failed++;
        $display("FAIL %s latency: got %0d want %0d", e.name, k, LAT);
      end
      tests_run++;
      if (busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s busy_at_done: got %b want 0", e.name, busy);
      end
      if (e.chk_oc) begin
        tests_run++;
        if (on_curve !== e.oc) begin
          tests_failed++;
          $display("FAIL %s on_curve: got %b want %b", e.name, on_curve, e.oc);
        end
      end
      tests_run++;
      if (range_err !== e.re) begin
        tests_failed++;
        $display("FAIL %s range_err: got %b want %b", e.name, range_err, e.re);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (done !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s done_pulse_width: got %b want 0", e.name, done);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    inf   = 1'b0;
    p     = '0;
    a     = '0;
    b     = '0;
    x     = '0;
    y     = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, on_curve, range_err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_values: got %b%b%b%b want 0000", busy, done, on_curve, range_err);
    end
    reset = 1'b1;
  endtask

  task automatic test_valid_point();
    drive_start(1'b0, 23, 1, 1, 3, 10, "valid_3_10");
    wait_result(0);
  endtask

  task automatic test_invalid_point();
    drive_start(1'b0, 23, 1, 1, 3, 11, "invalid_3_11");
    wait_result(0);
  endtask

  task automatic test_infinity();
    drive_start(1'b1, 23, 1, 1, 5, 7, "inf_5_7");
    wait_result(0);
    drive_start(1'b1, 23, 1, 1, 30, 40, "inf_out_of_range");
    wait_result(0);
  endtask

  task automatic test_zero_coords();
    drive_start(1'b0, 23, 1, 1, 0, 1, "x0_y1");
    wait_result(0);
    drive_start(1'b0, 23, 1, 1, 1, 0, "x1_y0");
    wait_result(0);
  endtask

  task automatic test_busy_ignore();
    bit extra;
    extra = 1'b0;
    drive_start(1'b0, 23, 1, 1, 3, 10, "busy_ignore");
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) begin
        start = 1'b1;
        inf   = 1'b0;
        p     = 8'd23;
        a     = 8'd1;
        b     = 8'd1;
        x     = 8'd3;
        y     = 8'd11;
      end
      if (i == 10) start = 1'b0;
    end
    wait_result(10);
    for (int i = 0; i < LAT + 10; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    tests_run++;
    if (extra) begin
      tests_failed++;
      $display("FAIL busy_ignore_no_queue: got extra activity want idle");
    end
  endtask

  task automatic test_reset_mid_op();
    bit stray;
    stray = 1'b0;
    drive_start(1'b0, 23, 1, 1, 3, 10, "reset_mid_op");
    for (int i = 1; i <= 19; i++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    tests_run++;
    if ({busy, done, on_curve, range_err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_mid_op_outputs: got %b%b%b%b want 0000", busy, done, on_curve,
               range_err);
    end
    for (int i = 0; i < LAT + 10; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) stray = 1'b1;
    end
    tests_run++;
    if (stray) begin
      tests_failed++;
      $display("FAIL reset_mid_op_no_done: got done pulse want none");
    end
    drive_start(1'b0, 23, 1, 1, 3, 10, "after_reset");
    wait_result(0);
  endtask

  task automatic test_range();
    drive_start(1'b0, 23, 1, 1, 30, 10, "range_x30");
    wait_result(0);
    drive_start(1'b0, 23, 1, 1, 3, 23, "range_y_eq_p");
    wait_result(0);
  endtask

  task automatic test_wide_operands();
    drive_start(1'b0, 251, 250, 250, 250, 250, "wide_251");
    wait_result(0);
    drive_start(1'b0, 255, 254, 254, 254, 254, "wide_255");
    wait_result(0);
    for (int i = 0; i < 6; i++) begin
      int unsigned mp;
      int unsigned ma;
      int unsigned mb;
      int unsigned mx;
      int unsigned my;
      mp = (i % 2 == 0) ? 251 : 255;
      ma = $urandom_range(mp - 1);
      mb = $urandom_range(mp - 1);
      mx = $urandom_range(mp - 1);
      my = $urandom_range(mp - 1);
      if (i < 4) begin
        for (int unsigned yy = 0; yy < mp; yy++) begin
          if (model_on_curve(mp, ma, mb, mx, yy)) begin
            my = yy;
            break;
          end
        end
      end
      drive_start(1'b0, mp, ma, mb, mx, my, $sformatf("rand_%0d", i));
      wait_result(0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_valid_point();
    test_invalid_point();
    test_infinity();
    test_zero_coords();
    test_busy_ignore();
    test_reset_mid_op();
    test_range();
    test_wide_operands();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
